// File: rtl/int_issue_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : int_iq_if
//  Purpose  : Bundle for the integer issue queue. Carries the flush and
//             dispatch write port, the CDB snoop port and the ALU issue
//             port together with the full/empty status.
//  Ports    : master - dispatcher/CDB/ALU side (drives i_*, cdb_*)
//             slave  - the issue queue itself (drives o_*)
//  Revision : 1.0 - initial release
// ============================================================================
interface int_iq_if #(
   parameter int TAG_W  = 6,
   parameter int DATA_W = 32
);
   // flush and dispatch write port
   logic              i_flush;
   logic              i_dispatch_en;
   logic [6:0]        i_opcode;
   logic [2:0]        i_func3;
   logic [6:0]        i_func7;
   logic [TAG_W:0]    i_rs1_tag;      // [TAG_W]=1: pending on tag [TAG_W-1:0]
   logic [DATA_W-1:0] i_rs1_data;
   logic [TAG_W:0]    i_rs2_tag;
   logic [DATA_W-1:0] i_rs2_data;
   logic [DATA_W-1:0] i_imm;
   logic [DATA_W-1:0] i_jmp_br_addr;
   logic [TAG_W-1:0]  i_rd_tag;
   // common data bus snoop
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   // issue port
   logic              i_issue_rdy;
   logic              o_issue_valid;
   logic [6:0]        o_issue_opcode;
   logic [2:0]        o_issue_func3;
   logic [6:0]        o_issue_func7;
   logic [DATA_W-1:0] o_issue_rs1_data;
   logic [DATA_W-1:0] o_issue_rs2_data;
   logic [DATA_W-1:0] o_issue_imm;
   logic [DATA_W-1:0] o_issue_jmp_br_addr;
   logic [TAG_W-1:0]  o_issue_rd_tag;
   // status
   logic              o_full;
   logic              o_empty;

   modport master (
      output i_flush, i_dispatch_en, i_opcode, i_func3, i_func7,
             i_rs1_tag, i_rs1_data, i_rs2_tag, i_rs2_data, i_imm,
             i_jmp_br_addr, i_rd_tag, cdb_valid, cdb_tag, cdb_data,
             i_issue_rdy,
      input  o_issue_valid, o_issue_opcode, o_issue_func3, o_issue_func7,
             o_issue_rs1_data, o_issue_rs2_data, o_issue_imm,
             o_issue_jmp_br_addr, o_issue_rd_tag, o_full, o_empty
   );

   modport slave (
      input  i_flush, i_dispatch_en, i_opcode, i_func3, i_func7,
             i_rs1_tag, i_rs1_data, i_rs2_tag, i_rs2_data, i_imm,
             i_jmp_br_addr, i_rd_tag, cdb_valid, cdb_tag, cdb_data,
             i_issue_rdy,
      output o_issue_valid, o_issue_opcode, o_issue_func3, o_issue_func7,
             o_issue_rs1_data, o_issue_rs2_data, o_issue_imm,
             o_issue_jmp_br_addr, o_issue_rd_tag, o_full, o_empty
   );
endinterface
`default_nettype wire

// File: rtl/int_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : int_issue_queue
//  Purpose  : Integer reservation station. Age-ordered compacting queue
//             (index 0 = oldest) that captures late operands from the CDB
//             and issues the oldest fully-ready entry to the integer ALU.
//  Ports    : i_clk   - clock, rising edge
//             i_rst_n - synchronous reset, active low
//             iq      - int_iq_if slave: dispatch, CDB snoop, issue, status
//  Config   : INT_IQ_CDB_BYPASS_EN - when defined, an entry whose last
//             pending operands match the current CDB broadcast is issuable
//             in the same cycle, with cdb_data muxed into the issue packet.
//  Revision : 1.0 - initial release
// ============================================================================
module int_issue_queue #(
   parameter int DEPTH  = 4,
   parameter int TAG_W  = 6,
   parameter int DATA_W = 32
) (
   input  wire logic i_clk,
   input  wire logic i_rst_n,
   int_iq_if.slave   iq
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

   typedef struct packed {
      logic              valid;
      logic              rs1_pend;
      logic [TAG_W-1:0]  rs1_tag;
      logic [DATA_W-1:0] rs1_data;
      logic              rs2_pend;
      logic [TAG_W-1:0]  rs2_tag;
      logic [DATA_W-1:0] rs2_data;
      logic [6:0]        opcode;
      logic [2:0]        func3;
      logic [6:0]        func7;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] addr;
      logic [TAG_W-1:0]  rd_tag;
   } entry_t;

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   // Entries after this cycle's CDB capture; the extra top slot is an
   // always-empty entry shifted into the vacated position on issue.
   entry_t           ent_cap [DEPTH+1];
   entry_t           new_ent;
   entry_t           sel_ent;
   logic [DEPTH-1:0] rdy;
   logic             sel_found;
   logic [IDX_W-1:0] sel_idx;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] wr_idx;
   logic             full, empty, fire, disp_ok;

   // ---------------------------------------------------------------
   // CDB capture on stored entries
   // ---------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_cap[i] = ent_q[i];
         if (iq.cdb_valid && ent_q[i].valid && ent_q[i].rs1_pend &&
             (ent_q[i].rs1_tag == iq.cdb_tag)) begin
            ent_cap[i].rs1_pend = 1'b0;
            ent_cap[i].rs1_data = iq.cdb_data;
         end
         if (iq.cdb_valid && ent_q[i].valid && ent_q[i].rs2_pend &&
             (ent_q[i].rs2_tag == iq.cdb_tag)) begin
            ent_cap[i].rs2_pend = 1'b0;
            ent_cap[i].rs2_data = iq.cdb_data;
         end
      end
      ent_cap[DEPTH] = '0;
   end

   // ---------------------------------------------------------------
   // Readiness
   // ---------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
`ifdef INT_IQ_CDB_BYPASS_EN
         // wake-up counts in the same cycle as the broadcast
         rdy[i] = ent_cap[i].valid && !ent_cap[i].rs1_pend && !ent_cap[i].rs2_pend;
`else
         // only operands already captured in a previous cycle count
         rdy[i] = ent_q[i].valid && !ent_q[i].rs1_pend && !ent_q[i].rs2_pend;
`endif
      end
   end

   // ---------------------------------------------------------------
   // Oldest-first select: scanning downward leaves the lowest index.
   // Issue data is taken from the captured view; for a non-pending
   // operand it equals the stored value, so only the bypass build
   // ever sees cdb_data here.
   // ---------------------------------------------------------------
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_ent   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (rdy[i]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
            sel_ent   = ent_cap[i];
         end
      end
   end

   assign iq.o_issue_valid       = sel_found;
   assign iq.o_issue_opcode      = sel_ent.opcode;
   assign iq.o_issue_func3       = sel_ent.func3;
   assign iq.o_issue_func7       = sel_ent.func7;
   assign iq.o_issue_rs1_data    = sel_ent.rs1_data;
   assign iq.o_issue_rs2_data    = sel_ent.rs2_data;
   assign iq.o_issue_imm         = sel_ent.imm;
   assign iq.o_issue_jmp_br_addr = sel_ent.addr;
   assign iq.o_issue_rd_tag      = sel_ent.rd_tag;

   assign full        = (count_q == C_DEPTH);
   assign empty       = (count_q == '0);
   assign iq.o_full   = full;
   assign iq.o_empty  = empty;

   // Flush wins over both handshakes. Full ignores a same-cycle issue.
   assign fire    = sel_found && iq.i_issue_rdy && !iq.i_flush;
   assign disp_ok = iq.i_dispatch_en && !full && !iq.i_flush;
   assign wr_idx  = fire ? (count_q - CNT_W'(1)) : count_q;

   // ---------------------------------------------------------------
   // Incoming entry, with capture of a same-cycle CDB broadcast
   // ---------------------------------------------------------------
   always_comb begin
      new_ent          = '0;
      new_ent.valid    = 1'b1;
      new_ent.rs1_pend = iq.i_rs1_tag[TAG_W];
      new_ent.rs1_tag  = iq.i_rs1_tag[TAG_W-1:0];
      new_ent.rs1_data = iq.i_rs1_data;
      new_ent.rs2_pend = iq.i_rs2_tag[TAG_W];
      new_ent.rs2_tag  = iq.i_rs2_tag[TAG_W-1:0];
      new_ent.rs2_data = iq.i_rs2_data;
      new_ent.opcode   = iq.i_opcode;
      new_ent.func3    = iq.i_func3;
      new_ent.func7    = iq.i_func7;
      new_ent.imm      = iq.i_imm;
      new_ent.addr     = iq.i_jmp_br_addr;
      new_ent.rd_tag   = iq.i_rd_tag;
      if (iq.cdb_valid && iq.i_rs1_tag[TAG_W] && (iq.i_rs1_tag[TAG_W-1:0] == iq.cdb_tag)) begin
         new_ent.rs1_pend = 1'b0;
         new_ent.rs1_data = iq.cdb_data;
      end
      if (iq.cdb_valid && iq.i_rs2_tag[TAG_W] && (iq.i_rs2_tag[TAG_W-1:0] == iq.cdb_tag)) begin
         new_ent.rs2_pend = 1'b0;
         new_ent.rs2_data = iq.cdb_data;
      end
   end

   // ---------------------------------------------------------------
   // Next state: compact above the issued slot, then write dispatch
   // ---------------------------------------------------------------
   always_comb begin
      for (int j = 0; j < DEPTH; j++) begin
         if (fire && (IDX_W'(j) >= sel_idx)) begin
            ent_d[j] = ent_cap[j+1];
         end else begin
            ent_d[j] = ent_cap[j];
         end
         if (disp_ok && (wr_idx == CNT_W'(j))) begin
            ent_d[j] = new_ent;
         end
         if (iq.i_flush) begin
            ent_d[j].valid = 1'b0;
         end
      end
      if (iq.i_flush) begin
         count_d = '0;
      end else begin
         count_d = count_q + CNT_W'(disp_ok) - CNT_W'(fire);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         count_q <= '0;
         for (int j = 0; j < DEPTH; j++) begin
            ent_q[j] <= '0;
         end
      end else begin
         count_q <= count_d;
         for (int j = 0; j < DEPTH; j++) begin
            ent_q[j] <= ent_d[j];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_int_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_issue_queue
//  Purpose  : Self-checking bench for int_issue_queue: directed scenarios
//             plus randomized traffic against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_int_issue_queue;

   localparam int DEPTH  = 4;
   localparam int TAG_W  = 6;
   localparam int DATA_W = 32;
`ifdef INT_IQ_CDB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   int_iq_if #(.TAG_W(TAG_W), .DATA_W(DATA_W)) bus ();

   int_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .iq      (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        p1;
      logic [5:0]  t1;
      logic [31:0] d1;
      logic        p2;
      logic [5:0]  t2;
      logic [31:0] d2;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] adr;
      logic [5:0]  rd;
   } m_ent_t;

   m_ent_t mq[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.i_flush       = 1'b0;
      bus.i_dispatch_en = 1'b0;
      bus.i_opcode      = '0;
      bus.i_func3       = '0;
      bus.i_func7       = '0;
      bus.i_rs1_tag     = '0;
      bus.i_rs1_data    = '0;
      bus.i_rs2_tag     = '0;
      bus.i_rs2_data    = '0;
      bus.i_imm         = '0;
      bus.i_jmp_br_addr = '0;
      bus.i_rd_tag      = '0;
      bus.cdb_valid     = 1'b0;
      bus.cdb_tag       = '0;
      bus.cdb_data      = '0;
   endtask

   task automatic drive_op(input logic p1, input logic [5:0] t1, input logic [31:0] d1,
                           input logic p2, input logic [5:0] t2, input logic [31:0] d2,
                           input logic [5:0] rd);
      bus.i_dispatch_en = 1'b1;
      bus.i_opcode      = 7'h33;
      bus.i_func3       = 3'h0;
      bus.i_func7       = 7'h00;
      bus.i_rs1_tag     = {p1, t1};
      bus.i_rs1_data    = d1;
      bus.i_rs2_tag     = {p2, t2};
      bus.i_rs2_data    = d2;
      bus.i_imm         = 32'h0;
      bus.i_jmp_br_addr = 32'h100;
      bus.i_rd_tag      = rd;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      bus.i_issue_rdy = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.o_issue_valid, bus.o_full, bus.o_empty} !== 3'b001) begin
         errors++;
         $display("FAIL reset_status: got v/f/e=%b expected 001",
                  {bus.o_issue_valid, bus.o_full, bus.o_empty});
      end
      checks++;
      if ({bus.o_issue_rs1_data, bus.o_issue_rs2_data, bus.o_issue_rd_tag} !== '0) begin
         errors++;
         $display("FAIL reset_data: got rs1=%h rs2=%h rd=%h expected zeros",
                  bus.o_issue_rs1_data, bus.o_issue_rs2_data, bus.o_issue_rd_tag);
      end
   endtask

   task automatic test_basic();
      bus.i_issue_rdy = 1'b1;
      drive_op(1'b0, 6'd0, 32'd5, 1'b0, 6'd0, 32'd7, 6'd3);
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({bus.o_issue_valid, bus.o_issue_opcode, bus.o_issue_rs1_data, bus.o_issue_rs2_data, bus.o_issue_rd_tag}
          !== {1'b1, 7'h33, 32'd5, 32'd7, 6'd3}) begin
         errors++;
         $display("FAIL basic_issue: got v=%b op=%h rs1=%0d rs2=%0d rd=%0d expected 1 33 5 7 3",
                  bus.o_issue_valid, bus.o_issue_opcode, bus.o_issue_rs1_data,
                  bus.o_issue_rs2_data, bus.o_issue_rd_tag);
      end
      tick();
      @(negedge clk);
      checks++;
      if ({bus.o_issue_valid, bus.o_empty} !== 2'b01) begin
         errors++;
         $display("FAIL basic_empty: got v/e=%b expected 01", {bus.o_issue_valid, bus.o_empty});
      end
   endtask

   task automatic test_cdb_wakeup();
      bus.i_issue_rdy = 1'b1;
      drive_op(1'b1, 6'd9, 32'd0, 1'b0, 6'd0, 32'd2, 6'd10);
      tick();
      idle_inputs();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (bus.o_issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL wake_hold%0d: got valid=%b expected 0", k, bus.o_issue_valid);
         end
         tick();
      end
      bus.cdb_valid = 1'b1;
      bus.cdb_tag   = 6'd9;
      bus.cdb_data  = 32'h55;
`ifdef INT_IQ_CDB_BYPASS_EN
      @(negedge clk);
      checks++;
      if ({bus.o_issue_valid, bus.o_issue_rs1_data} !== {1'b1, 32'h55}) begin
         errors++;
         $display("FAIL wake_bypass: got v=%b rs1=%h expected 1 55", bus.o_issue_valid, bus.o_issue_rs1_data);
      end
      tick();
      bus.cdb_valid = 1'b0;
`else
      @(negedge clk);
      checks++;
      if (bus.o_issue_valid !== 1'b0) begin
         errors++;
         $display("FAIL wake_same_cycle: got valid=%b expected 0", bus.o_issue_valid);
      end
      tick();
      bus.cdb_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.o_issue_valid, bus.o_issue_rs1_data} !== {1'b1, 32'h55}) begin
         errors++;
         $display("FAIL wake_issue: got v=%b rs1=%h expected 1 55", bus.o_issue_valid, bus.o_issue_rs1_data);
      end
      tick();
`endif
      @(negedge clk);
      checks++;
      if (bus.o_empty !== 1'b1) begin
         errors++;
         $display("FAIL wake_empty: got empty=%b expected 1", bus.o_empty);
      end
   endtask

   task automatic test_order();
      // younger ready op overtakes an older pending one
      bus.i_issue_rdy = 1'b1;
      drive_op(1'b1, 6'd4, 32'd0, 1'b0, 6'd0, 32'd1, 6'd20);
      tick();
      drive_op(1'b0, 6'd0, 32'h11, 1'b0, 6'd0, 32'h22, 6'd21);
      @(negedge clk);
      checks++;
      if (bus.o_issue_valid !== 1'b0) begin
         errors++;
         $display("FAIL order_pend: got valid=%b expected 0", bus.o_issue_valid);
      end
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({bus.o_issue_valid, bus.o_issue_rd_tag} !== {1'b1, 6'd21}) begin
         errors++;
         $display("FAIL order_b_first: got v=%b rd=%0d expected 1 21", bus.o_issue_valid, bus.o_issue_rd_tag);
      end
      tick();
      bus.cdb_valid = 1'b1;
      bus.cdb_tag   = 6'd4;
      bus.cdb_data  = 32'h44;
`ifndef INT_IQ_CDB_BYPASS_EN
      tick();
      bus.cdb_valid = 1'b0;
`endif
      @(negedge clk);
      checks++;
      if ({bus.o_issue_valid, bus.o_issue_rd_tag, bus.o_issue_rs1_data} !== {1'b1, 6'd20, 32'h44}) begin
         errors++;
         $display("FAIL order_a_after: got v=%b rd=%0d rs1=%h expected 1 20 44",
                  bus.o_issue_valid, bus.o_issue_rd_tag, bus.o_issue_rs1_data);
      end
      tick();
      bus.cdb_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.o_empty !== 1'b1) begin
         errors++;
         $display("FAIL order_empty_a: got empty=%b expected 1", bus.o_empty);
      end
      // both ready while stalled: the older one must leave first
      bus.i_issue_rdy = 1'b0;
      drive_op(1'b1, 6'd4, 32'd0, 1'b0, 6'd0, 32'd1, 6'd22);
      tick();
      drive_op(1'b0, 6'd0, 32'h33, 1'b0, 6'd0, 32'h34, 6'd23);
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({bus.o_issue_valid, bus.o_issue_rd_tag} !== {1'b1, 6'd23}) begin
         errors++;
         $display("FAIL order_only_b: got v=%b rd=%0d expected 1 23", bus.o_issue_valid, bus.o_issue_rd_tag);
      end
      bus.cdb_valid = 1'b1;
      bus.cdb_tag   = 6'd4;
      bus.cdb_data  = 32'h66;
      tick();
      bus.cdb_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.o_issue_rd_tag, bus.o_issue_rs1_data} !== {6'd22, 32'h66}) begin
         errors++;
         $display("FAIL order_a_oldest: got rd=%0d rs1=%h expected 22 66", bus.o_issue_rd_tag, bus.o_issue_rs1_data);
      end
      bus.i_issue_rdy = 1'b1;
      tick();
      @(negedge clk);
      checks++;
      if ({bus.o_issue_valid, bus.o_issue_rd_tag} !== {1'b1, 6'd23}) begin
         errors++;
         $display("FAIL order_b_second: got v=%b rd=%0d expected 1 23", bus.o_issue_valid, bus.o_issue_rd_tag);
      end
      tick();
      @(negedge clk);
      checks++;
      if (bus.o_empty !== 1'b1) begin
         errors++;
         $display("FAIL order_empty_b: got empty=%b expected 1", bus.o_empty);
      end
   endtask

   task automatic test_full();
      bus.i_issue_rdy = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         drive_op(1'b0, 6'd0, 32'(i + 1), 1'b0, 6'd0, 32'd0, 6'(30 + i));
         tick();
      end
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({bus.o_full, bus.o_empty} !== 2'b10) begin
         errors++;
         $display("FAIL full_flag: got f/e=%b expected 10", {bus.o_full, bus.o_empty});
      end
      drive_op(1'b0, 6'd0, 32'd99, 1'b0, 6'd0, 32'd0, 6'd34);
      tick();
      // a dispatch while full and issuing must still be dropped
      drive_op(1'b0, 6'd0, 32'd98, 1'b0, 6'd0, 32'd0, 6'd35);
      bus.i_issue_rdy = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.o_issue_valid, bus.o_issue_rd_tag, bus.o_issue_rs1_data} !== {1'b1, 6'(30 + i), 32'(i + 1)}) begin
            errors++;
            $display("FAIL full_drain%0d: got v=%b rd=%0d rs1=%0d expected 1 %0d %0d", i,
                     bus.o_issue_valid, bus.o_issue_rd_tag, bus.o_issue_rs1_data, 30 + i, i + 1);
         end
         tick();
         idle_inputs();
      end
      @(negedge clk);
      checks++;
      if ({bus.o_issue_valid, bus.o_empty} !== 2'b01) begin
         errors++;
         $display("FAIL full_dropped: got v/e=%b expected 01", {bus.o_issue_valid, bus.o_empty});
      end
   endtask

   task automatic test_cdb_same_cycle();
      bus.i_issue_rdy = 1'b0;
      drive_op(1'b1, 6'd12, 32'd0, 1'b0, 6'd0, 32'd3, 6'd40);
      bus.cdb_valid = 1'b1;
      bus.cdb_tag   = 6'd12;
      bus.cdb_data  = 32'hAB;
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({bus.o_issue_valid, bus.o_issue_rs1_data, bus.o_issue_rd_tag} !== {1'b1, 32'hAB, 6'd40}) begin
         errors++;
         $display("FAIL samecyc_capture: got v=%b rs1=%h rd=%0d expected 1 ab 40",
                  bus.o_issue_valid, bus.o_issue_rs1_data, bus.o_issue_rd_tag);
      end
      bus.i_issue_rdy = 1'b1;
      tick();
      @(negedge clk);
      checks++;
      if (bus.o_empty !== 1'b1) begin
         errors++;
         $display("FAIL samecyc_empty: got empty=%b expected 1", bus.o_empty);
      end
   endtask

   task automatic test_flush();
      bus.i_issue_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_op(1'b0, 6'd0, 32'd1, 1'b0, 6'd0, 32'd2, 6'(50 + i));
         tick();
      end
      drive_op(1'b0, 6'd0, 32'd1, 1'b0, 6'd0, 32'd2, 6'd53);
      bus.i_flush     = 1'b1;
      bus.i_issue_rdy = 1'b1;
      tick();
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({bus.o_issue_valid, bus.o_empty} !== 2'b01) begin
         errors++;
         $display("FAIL flush_clear: got v/e=%b expected 01", {bus.o_issue_valid, bus.o_empty});
      end
      bus.i_issue_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_op(1'b0, 6'd0, 32'd7, 1'b0, 6'd0, 32'd8, 6'(54 + i));
         tick();
      end
      drive_op(1'b0, 6'd0, 32'd7, 1'b0, 6'd0, 32'd8, 6'd57);
      bus.i_issue_rdy = 1'b1;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      idle_inputs();
      @(negedge clk);
      checks++;
      if ({bus.o_issue_valid, bus.o_full, bus.o_empty, bus.o_issue_rd_tag, bus.o_issue_rs1_data}
          !== {3'b001, 6'd0, 32'd0}) begin
         errors++;
         $display("FAIL reset_midstream: got v/f/e=%b rd=%0d rs1=%h expected 001 0 0",
                  {bus.o_issue_valid, bus.o_full, bus.o_empty}, bus.o_issue_rd_tag, bus.o_issue_rs1_data);
      end
      bus.i_issue_rdy = 1'b0;
   endtask

   task automatic test_random();
      int          sel;
      int          n0;
      m_ent_t      e;
      m_ent_t      ne;
      logic        r1, r2;
      logic [31:0] x1, x2;
      rst_n = 1'b0;
      idle_inputs();
      tick();
      rst_n = 1'b1;
      mq.delete();
      for (int cyc = 0; cyc < 600; cyc++) begin
         bus.i_flush       = ($urandom_range(0, 49) == 0);
         bus.i_dispatch_en = ($urandom_range(0, 9) < 6);
         bus.i_opcode      = 7'($urandom);
         bus.i_func3       = 3'($urandom);
         bus.i_func7       = 7'($urandom);
         bus.i_rs1_tag     = {($urandom_range(0, 2) == 0), 6'($urandom_range(0, 7))};
         bus.i_rs1_data    = $urandom;
         bus.i_rs2_tag     = {($urandom_range(0, 2) == 0), 6'($urandom_range(0, 7))};
         bus.i_rs2_data    = $urandom;
         bus.i_imm         = $urandom;
         bus.i_jmp_br_addr = $urandom;
         bus.i_rd_tag      = 6'($urandom);
         bus.cdb_valid     = ($urandom_range(0, 9) < 4);
         bus.cdb_tag       = 6'($urandom_range(0, 7));
         bus.cdb_data      = $urandom;
         bus.i_issue_rdy   = ($urandom_range(0, 9) < 5);
         @(negedge clk);
         sel = -1;
         for (int i = 0; i < mq.size(); i++) begin
            r1 = !mq[i].p1 || (BYP && bus.cdb_valid && (mq[i].t1 == bus.cdb_tag));
            r2 = !mq[i].p2 || (BYP && bus.cdb_valid && (mq[i].t2 == bus.cdb_tag));
            if (r1 && r2 && (sel < 0)) sel = i;
         end
         checks++;
         if (bus.o_issue_valid !== (sel >= 0)) begin
            errors++;
            $display("FAIL rand_valid cyc=%0d: got %b expected %b", cyc, bus.o_issue_valid, (sel >= 0));
         end
         if (sel >= 0) begin
            e  = mq[sel];
            x1 = e.p1 ? bus.cdb_data : e.d1;
            x2 = e.p2 ? bus.cdb_data : e.d2;
            checks++;
            if ({bus.o_issue_opcode, bus.o_issue_func3, bus.o_issue_func7, bus.o_issue_rs1_data,
                 bus.o_issue_rs2_data, bus.o_issue_imm, bus.o_issue_jmp_br_addr, bus.o_issue_rd_tag}
                !== {e.op, e.f3, e.f7, x1, x2, e.imm, e.adr, e.rd}) begin
               errors++;
               $display("FAIL rand_packet cyc=%0d: got op=%h rs1=%h rs2=%h imm=%h adr=%h rd=%0d expected op=%h rs1=%h rs2=%h imm=%h adr=%h rd=%0d",
                        cyc, bus.o_issue_opcode, bus.o_issue_rs1_data, bus.o_issue_rs2_data,
                        bus.o_issue_imm, bus.o_issue_jmp_br_addr, bus.o_issue_rd_tag,
                        e.op, x1, x2, e.imm, e.adr, e.rd);
            end
         end
         checks++;
         if ({bus.o_full, bus.o_empty} !== {(mq.size() == DEPTH), (mq.size() == 0)}) begin
            errors++;
            $display("FAIL rand_status cyc=%0d: got f/e=%b expected size %0d",
                     cyc, {bus.o_full, bus.o_empty}, mq.size());
         end
         @(posedge clk);
         if (bus.i_flush) begin
            mq.delete();
         end else begin
            n0 = mq.size();
            if ((sel >= 0) && bus.i_issue_rdy) mq.delete(sel);
            for (int i = 0; i < mq.size(); i++) begin
               if (bus.cdb_valid && mq[i].p1 && (mq[i].t1 == bus.cdb_tag)) begin
                  mq[i].p1 = 1'b0;
                  mq[i].d1 = bus.cdb_data;
               end
               if (bus.cdb_valid && mq[i].p2 && (mq[i].t2 == bus.cdb_tag)) begin
                  mq[i].p2 = 1'b0;
                  mq[i].d2 = bus.cdb_data;
               end
            end
            if (bus.i_dispatch_en && (n0 < DEPTH)) begin
               ne.p1  = bus.i_rs1_tag[6];
               ne.t1  = bus.i_rs1_tag[5:0];
               ne.d1  = bus.i_rs1_data;
               ne.p2  = bus.i_rs2_tag[6];
               ne.t2  = bus.i_rs2_tag[5:0];
               ne.d2  = bus.i_rs2_data;
               ne.op  = bus.i_opcode;
               ne.f3  = bus.i_func3;
               ne.f7  = bus.i_func7;
               ne.imm = bus.i_imm;
               ne.adr = bus.i_jmp_br_addr;
               ne.rd  = bus.i_rd_tag;
               if (bus.cdb_valid && ne.p1 && (ne.t1 == bus.cdb_tag)) begin
                  ne.p1 = 1'b0;
                  ne.d1 = bus.cdb_data;
               end
               if (bus.cdb_valid && ne.p2 && (ne.t2 == bus.cdb_tag)) begin
                  ne.p2 = 1'b0;
                  ne.d2 = bus.cdb_data;
               end
               mq.push_back(ne);
            end
         end
         #1;
      end
      idle_inputs();
      bus.i_issue_rdy = 1'b0;
   endtask

   initial begin
      idle_inputs();
      bus.i_issue_rdy = 1'b0;
      test_reset();
      test_basic();
      test_cdb_wakeup();
      test_order();
      test_full();
      test_cdb_same_cycle();
      test_flush();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
